// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC sequencer: memory window defaults,
// FSM state encoding and redirect-source select encoding.
package npc_pkg;

   localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
   localparam logic [31:0] IM_TOP_DEF  = 32'h0000_3FFC;

   typedef enum logic {
      SEQ  = 1'b0,
      HOLD = 1'b1
   } npc_state_e;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } npc_sel_e;

   // Fixed priority: register jumps win over direct jumps, which win over branches.
   function automatic npc_sel_e npc_select(input logic br, input logic j, input logic jr);
      npc_sel_e s;
      if (jr)      s = SEL_JR;
      else if (j)  s = SEL_J;
      else if (br) s = SEL_BR;
      else         s = SEL_PC4;
      return s;
   endfunction

endpackage

// File: rtl/npc_range_chk.sv
// Flags a redirect target that is not word aligned or lies outside the
// instruction-memory window [IM_BASE, IM_TOP]. Purely combinational.
module npc_range_chk
   import npc_pkg::*;
#(
   parameter logic [31:0] IM_BASE = IM_BASE_DEF,
   parameter logic [31:0] IM_TOP  = IM_TOP_DEF
) (
   input  logic [31:0] addr,
   output logic        bad
);

   assign bad = (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_TOP);

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC selection with redirect capture across hazard stalls; npc/pc_en are zero latency.
// Optional stall-cycle counter is built only when NPC_SEQ_PERF_EN is defined.
module npc_sequencer
   import npc_pkg::*;
#(
   parameter logic [31:0] IM_BASE = IM_BASE_DEF,
   parameter logic [31:0] IM_TOP  = IM_TOP_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc4,
   input  logic        stall,
   input  logic        br_req,
   input  logic [31:0] br_target,
   input  logic        j_req,
   input  logic [31:0] j_target,
   input  logic        jr_req,
   input  logic [31:0] jr_target,
   output logic [31:0] npc,
   output logic        pc_en,
   output logic        redirect_pending,
   output logic        addr_err,
   output logic [31:0] stall_cnt
);

   npc_state_e  state_q, state_d;
   logic [31:0] pend_q, pend_d;
   logic        addr_err_q, addr_err_d;

   npc_sel_e    sel;
   logic [31:0] sel_target;
   logic        any_req;
   logic        target_bad;
   logic [31:0] npc_raw;

   always_comb begin
      sel        = npc_select(br_req, j_req, jr_req);
      sel_target = pc4;
      case (sel)
         SEL_BR:  sel_target = br_target;
         SEL_J:   sel_target = j_target;
         SEL_JR:  sel_target = jr_target;
         default: sel_target = pc4;
      endcase
      any_req = (sel != SEL_PC4);
   end

   npc_range_chk #(
      .IM_BASE (IM_BASE),
      .IM_TOP  (IM_TOP)
   ) u_range_chk (
      .addr (sel_target),
      .bad  (target_bad)
   );

   always_comb begin
      npc_raw = pc4;
      if (reset)
         npc_raw = IM_BASE;
      else if (state_q == HOLD)
         npc_raw = pend_q;
      else if (!stall && any_req)
         npc_raw = sel_target;
   end

   assign npc              = {npc_raw[31:2], 2'b00};
   assign pc_en            = !reset && !stall;
   assign redirect_pending = !reset && (state_q == HOLD);
   assign addr_err         = addr_err_q;

   // Targets are only accepted (and thus checked) in SEQ; HOLD replays an already-checked pend.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      addr_err_d = addr_err_q | ((state_q == SEQ) && any_req && target_bad);
      if (state_q == SEQ) begin
         if (stall && any_req) begin
            state_d = HOLD;
            pend_d  = sel_target;
         end
      end else if (!stall) begin
         state_d = SEQ;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SEQ;
         pend_q     <= IM_BASE;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         addr_err_q <= addr_err_d;
      end
   end

`ifdef NPC_SEQ_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= 32'd0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
